pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 4-latch uop pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Generates per-latch stall and flush strobes for memory wait states, load-use hazards and branch redirects.
- Runs interrupt entry by draining to an instruction boundary (EOI), then pulsing an acknowledge.
- Stall outputs are Mealy: same-cycle, so latches freeze on the cycle the condition appears.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the uop pipeline stall/flush control.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        INT_DRAIN = 2'd2,
        INT_HOLD  = 2'd3
    } state_t;

    localparam int unsigned REG_ID_W = 5;
    localparam logic [REG_ID_W-1:0] REG_NONE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in ID/EXE writes a register that the uop
// in IF/ID reads. Register 0 is never a real destination.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                ld_valid,
    input  logic [REG_ID_W-1:0] ld_wr_id,
    input  logic [REG_ID_W-1:0] src1_id,
    input  logic [REG_ID_W-1:0] src2_id,
    input  logic                src1_use,
    input  logic                src2_use,
    output logic                hazard
);

    // Hazard when either read source matches a live load destination
    always_comb begin
        hazard = ld_valid && (ld_wr_id != REG_NONE) &&
                 ((src1_use && (src1_id == ld_wr_id)) ||
                  (src2_use && (src2_id == ld_wr_id)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the IF/ID, ID/EXE, EXE/MEM, MEM/WB
// latches: memory wait states, load-use bubbles, branch redirects and
// interrupt entry at an instruction boundary.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT     = 15,
    parameter int unsigned INT_HOLD_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                mem_req,
    input  logic                mem_rdy,
    input  logic                ld_valid,
    input  logic [REG_ID_W-1:0] ld_wr_id,
    input  logic [REG_ID_W-1:0] id_src1_id,
    input  logic [REG_ID_W-1:0] id_src2_id,
    input  logic                id_src1_use,
    input  logic                id_src2_use,
    input  logic                redirect,
    input  logic                eoi_mem,
    input  logic                int_req,
    output logic                stall_if,
    output logic                stall_id,
    output logic                stall_exe,
    output logic                stall_mem,
    output logic                flush_id,
    output logic                flush_exe,
    output logic                flush_mem,
    output logic                int_ack,
    output logic                mem_timeout,
    output logic [1:0]          state_dbg
);

    localparam int unsigned HOLD_W = (INT_HOLD_CYCLES < 2) ? 1 : $clog2(INT_HOLD_CYCLES + 1);
    localparam logic [3:0]        TIMEOUT_CNT = 4'(MEM_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(INT_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(1);

    state_t            state;
    state_t            ret_state;
    state_t            eff_state;
    logic [3:0]        wait_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              memwait;
    logic              ld_hazard;

    load_use_detect u_lud (
        .ld_valid (ld_valid),
        .ld_wr_id (ld_wr_id),
        .src1_id  (id_src1_id),
        .src2_id  (id_src2_id),
        .src1_use (id_src1_use),
        .src2_use (id_src2_use),
        .hazard   (ld_hazard)
    );

    // Wait-state detect; a wait that has reached the timeout is released.
    // The exit cycle of a wait behaves as the state being returned to, so
    // the pipeline is not idle for an extra cycle after the bus completes.
    always_comb begin
        memwait   = mem_req && !mem_rdy && (wait_cnt != TIMEOUT_CNT);
        eff_state = (state == MEM_WAIT) ? ret_state : state;
    end

    // Same-cycle stall/flush/ack strobes; stalls override all flushes
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_exe = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_exe = 1'b0;
        flush_mem = 1'b0;
        int_ack   = 1'b0;
        if (!RST) begin
            if (memwait) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_exe = 1'b1;
                stall_mem = 1'b1;
            end else if (eff_state == INT_HOLD) begin
                stall_if = 1'b1;
                flush_id = 1'b1;
            end else if (eff_state == INT_DRAIN && eoi_mem) begin
                int_ack   = 1'b1;
                flush_id  = 1'b1;
                flush_exe = 1'b1;
                flush_mem = 1'b1;
            end else if (redirect) begin
                flush_id  = 1'b1;
                flush_exe = 1'b1;
            end else if (ld_hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_exe = 1'b1;
            end
        end
    end

    // FSM, wait/hold counters and sticky timeout flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            ret_state   <= RUN;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (memwait) begin
            if (state != MEM_WAIT) begin
                ret_state <= state;
                state     <= MEM_WAIT;
                wait_cnt  <= 4'd1;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            if (state == MEM_WAIT) begin
                wait_cnt <= '0;
                if (wait_cnt == TIMEOUT_CNT) begin
                    mem_timeout <= 1'b1;
                end
            end
            case (eff_state)
                RUN: begin
                    state <= int_req ? INT_DRAIN : RUN;
                end
                INT_DRAIN: begin
                    if (eoi_mem) begin
                        state    <= INT_HOLD;
                        hold_cnt <= HOLD_INIT;
                    end else begin
                        state <= INT_DRAIN;
                    end
                end
                INT_HOLD: begin
                    if (hold_cnt <= HOLD_LAST) begin
                        state    <= RUN;
                        hold_cnt <= '0;
                    end else begin
                        state    <= INT_HOLD;
                        hold_cnt <= hold_cnt - HOLD_LAST;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change 1 time unit after the
// rising edge; combinational strobes are checked 1 unit later and registered
// state right after each edge.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       mem_req, mem_rdy, ld_valid, id_src1_use, id_src2_use;
    logic [4:0] ld_wr_id, id_src1_id, id_src2_id;
    logic       redirect, eoi_mem, int_req;
    logic       stall_if, stall_id, stall_exe, stall_mem;
    logic       flush_id, flush_exe, flush_mem, int_ack, mem_timeout;
    logic [1:0] state_dbg;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Packed view: {stall_if,stall_id,stall_exe,stall_mem,flush_id,flush_exe,flush_mem,int_ack}
    localparam logic [7:0] O_NONE   = 8'h00;
    localparam logic [7:0] O_STALL  = 8'hF0;
    localparam logic [7:0] O_HAZ    = 8'hC4;
    localparam logic [7:0] O_REDIR  = 8'h0C;
    localparam logic [7:0] O_ACK    = 8'h0F;
    localparam logic [7:0] O_HOLD   = 8'h88;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .INT_HOLD_CYCLES(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .mem_req     (mem_req),
        .mem_rdy     (mem_rdy),
        .ld_valid    (ld_valid),
        .ld_wr_id    (ld_wr_id),
        .id_src1_id  (id_src1_id),
        .id_src2_id  (id_src2_id),
        .id_src1_use (id_src1_use),
        .id_src2_use (id_src2_use),
        .redirect    (redirect),
        .eoi_mem     (eoi_mem),
        .int_req     (int_req),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_exe   (stall_exe),
        .stall_mem   (stall_mem),
        .flush_id    (flush_id),
        .flush_exe   (flush_exe),
        .flush_mem   (flush_mem),
        .int_ack     (int_ack),
        .mem_timeout (mem_timeout),
        .state_dbg   (state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {stall_if, stall_id, stall_exe, stall_mem,
                  flush_id, flush_exe, flush_mem, int_ack}, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        mem_req = 0; mem_rdy = 0; ld_valid = 0; ld_wr_id = 0;
        id_src1_id = 0; id_src2_id = 0; id_src1_use = 0; id_src2_use = 0;
        redirect = 0; eoi_mem = 0; int_req = 0;
    endtask

    initial begin
        idle();
        RST = 1;
        // Reset: strobes held low even with active requests
        mem_req = 1; int_req = 1;
        chk_out("rst_outs", O_NONE);
        tick(); tick();
        RST = 0; idle();
        chk("rst_state", {6'd0, state_dbg}, 8'd0);
        chk("rst_timeout", {7'd0, mem_timeout}, 8'd0);
        chk_out("idle_outs", O_NONE);

        // Three wait states then ready
        mem_req = 1; mem_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            chk_out("wait3_stall", O_STALL);
            tick();
            chk("wait3_state", {6'd0, state_dbg}, 8'd1);
        end
        mem_rdy = 1;
        chk_out("wait3_release", O_NONE);
        tick();
        chk("wait3_exit_state", {6'd0, state_dbg}, 8'd0);
        chk("wait3_timeout", {7'd0, mem_timeout}, 8'd0);

        // Zero-cycle access
        chk_out("zero_wait", O_NONE);
        tick();
        chk("zero_wait_state", {6'd0, state_dbg}, 8'd0);

        // Bus never ready: 15 stall cycles, released on the 16th
        mem_rdy = 0;
        for (int i = 0; i < 15; i++) begin
            chk_out("tmo_stall", O_STALL);
            tick();
        end
        chk_out("tmo_release", O_NONE);
        chk("tmo_not_yet", {7'd0, mem_timeout}, 8'd0);
        tick();
        mem_req = 0;
        chk("tmo_flag", {7'd0, mem_timeout}, 8'd1);
        chk("tmo_state", {6'd0, state_dbg}, 8'd0);
        tick(); tick();
        chk("tmo_sticky", {7'd0, mem_timeout}, 8'd1);

        // Load-use hazards
        ld_valid = 1; ld_wr_id = 5'd7; id_src2_id = 5'd7; id_src2_use = 1;
        chk_out("lu_src2", O_HAZ);
        tick();
        ld_wr_id = 5'd0; id_src2_id = 5'd0;
        chk_out("lu_reg0", O_NONE);
        tick();
        ld_wr_id = 5'd7; id_src2_id = 5'd3; id_src2_use = 1; id_src1_id = 5'd7; id_src1_use = 1;
        chk_out("lu_src1", O_HAZ);
        tick();
        id_src1_use = 0;
        chk_out("lu_src1_unused", O_NONE);
        tick();
        id_src1_use = 1; ld_valid = 0;
        chk_out("lu_not_load", O_NONE);
        tick();
        ld_valid = 1; redirect = 1;
        chk_out("redir_over_lu", O_REDIR);
        tick();
        idle();
        redirect = 1; mem_req = 1;
        chk_out("memwait_over_redir", O_STALL);
        tick();
        chk("memwait_redir_state", {6'd0, state_dbg}, 8'd1);
        mem_rdy = 1; redirect = 0;
        chk_out("memwait_redir_exit", O_NONE);
        tick();
        idle();

        // Interrupt: 1-cycle request, EOI four cycles later
        int_req = 1;
        chk_out("int_req_cycle", O_NONE);
        tick();
        int_req = 0;
        chk("int_drain_state", {6'd0, state_dbg}, 8'd2);
        tick();
        redirect = 1;
        chk_out("drain_redirect", O_REDIR);
        tick();
        redirect = 0;
        chk("drain_not_cancelled", {6'd0, state_dbg}, 8'd2);
        tick();
        eoi_mem = 1;
        chk_out("int_ack_flush", O_ACK);
        tick();
        eoi_mem = 0;
        chk("hold_state", {6'd0, state_dbg}, 8'd3);
        chk_out("hold_1", O_HOLD);
        tick();
        chk("hold_state2", {6'd0, state_dbg}, 8'd3);
        chk_out("hold_2", O_HOLD);
        tick();
        chk("hold_done_state", {6'd0, state_dbg}, 8'd0);
        chk_out("hold_done_outs", O_NONE);

        // Memory wait inside drain returns to drain
        int_req = 1;
        tick();
        int_req = 0; mem_req = 1;
        chk_out("drain_wait", O_STALL);
        tick();
        chk("drain_wait_state", {6'd0, state_dbg}, 8'd1);
        mem_rdy = 1;
        tick();
        idle();
        chk("drain_wait_return", {6'd0, state_dbg}, 8'd2);
        eoi_mem = 1;
        chk_out("drain_wait_ack", O_ACK);
        tick();
        eoi_mem = 0;
        tick(); tick();
        chk("drain_wait_run", {6'd0, state_dbg}, 8'd0);

        // Reset in MEM_WAIT after five wait cycles; clears sticky timeout
        mem_req = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_wait_state", {6'd0, state_dbg}, 8'd1);
        RST = 1;
        chk_out("rst_in_wait_outs", O_NONE);
        tick();
        RST = 0; idle();
        chk("rst_wait_state", {6'd0, state_dbg}, 8'd0);
        chk("rst_wait_timeout", {7'd0, mem_timeout}, 8'd0);
        chk_out("rst_wait_outs", O_NONE);

        // Reset in INT_HOLD
        int_req = 1;
        tick();
        int_req = 0; eoi_mem = 1;
        tick();
        eoi_mem = 0;
        chk("pre_rst_hold_state", {6'd0, state_dbg}, 8'd3);
        RST = 1;
        chk_out("rst_in_hold_outs", O_NONE);
        tick();
        RST = 0;
        chk("rst_hold_state", {6'd0, state_dbg}, 8'd0);
        chk_out("rst_hold_outs", O_NONE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
